// File: rtl/ex_mul_sequencer.sv
// ex_mul_sequencer: EX-stage sequencer for an iterative multiplier alongside the single-cycle ALU
module ex_mul_sequencer #(
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Flush,
  input  logic        Valid_ID_EX,
  input  logic        IsMul_ID_EX,
  input  logic        RegWrite_ID_EX,
  input  logic [4:0]  Rd_ID_EX,
  input  logic [31:0] OpA,
  input  logic [31:0] OpB,
  input  logic [31:0] ALUresult,
  output logic        Stall,
  output logic        RegWrite_EX,
  output logic [31:0] Result_EX,
  output logic [4:0]  Rd_EX,
  output logic        Busy,
  output logic        MulDone
);
  localparam int ITER = 32 / BITS_PER_CYCLE;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t      state, state_nx;
  logic [31:0] acc, mcand, mplier;
  logic [5:0]  count;
  logic [4:0]  rd_q;
  logic        rw_q;
  logic        accept, last;
  assign accept = state == IDLE && Valid_ID_EX && IsMul_ID_EX && !Flush;
  assign last   = count == 6'(ITER - 1);
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) state <= IDLE;
    else        state <= state_nx;
  always_comb begin
    state_nx = Flush ? IDLE :
               state == IDLE ? (accept ? BUSY : IDLE) :
               state == BUSY ? (last ? DONE : BUSY) : IDLE;
  end
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
      rd_q   <= '0;
      rw_q   <= 1'b0;
    end else if (Flush) begin
      acc   <= '0;
      count <= '0;
    end else if (accept) begin
      mcand  <= OpA;
      mplier <= OpB;
      rd_q   <= Rd_ID_EX;
      rw_q   <= RegWrite_ID_EX;
      acc    <= '0;
      count  <= '0;
    end else if (state == BUSY) begin
      // partial product of the low multiplier digit, kept to 32 bits
      acc    <= acc + mcand * 32'(mplier[BITS_PER_CYCLE-1:0]);
      mcand  <= mcand << BITS_PER_CYCLE;
      mplier <= mplier >> BITS_PER_CYCLE;
      count  <= count + 6'd1;
    end
  always_comb begin
    Busy        = Reset && state == BUSY;
    MulDone     = Reset && state == DONE && !Flush;
    Stall       = Reset && !Flush && (state == BUSY || accept);
    Result_EX   = !Reset ? 32'd0 : state == DONE ? acc : ALUresult;
    Rd_EX       = !Reset ? 5'd0 : state == DONE ? rd_q : Rd_ID_EX;
    RegWrite_EX = Reset && !Flush && Rd_EX != 5'd0 &&
                  (state == DONE ? rw_q : state == IDLE && Valid_ID_EX && !IsMul_ID_EX && RegWrite_ID_EX);
  end
endmodule

// File: tb/tb_ex_mul_sequencer.sv
// tb_ex_mul_sequencer: random and directed checks of three multiplier widths against a cycle-count model
module tb_ex_mul_sequencer;
  logic Clk = 0, Reset = 0, Flush = 0, Valid = 0, IsMul = 0, RegWr = 0;
  logic [4:0]  Rd = 0;
  logic [31:0] OpA = 0, OpB = 0, ALU = 0;
  logic        stall_v [3], rw_v [3], busy_v [3], done_v [3];
  logic [31:0] res_v [3];
  logic [4:0]  rd_v [3];
  int total = 0, bad = 0;
  localparam int IT [3] = '{16, 32, 4};
  int          rem [3] = '{0, 0, 0};
  logic [31:0] prod [3];
  logic [4:0]  mrd [3];
  logic        mrw [3];
  logic [31:0] r_c [3];
  logic [4:0]  rd_c [3];
  logic        rw_c [3];
  int          sc_c [3];
  logic [31:0] eres;
  logic [4:0]  erd;
  logic        est, ebz, edn, erw;

  always #5 Clk = ~Clk;

  ex_mul_sequencer #(.BITS_PER_CYCLE(2)) u0 (.Clk(Clk), .Reset(Reset), .Flush(Flush), .Valid_ID_EX(Valid),
    .IsMul_ID_EX(IsMul), .RegWrite_ID_EX(RegWr), .Rd_ID_EX(Rd), .OpA(OpA), .OpB(OpB), .ALUresult(ALU),
    .Stall(stall_v[0]), .RegWrite_EX(rw_v[0]), .Result_EX(res_v[0]), .Rd_EX(rd_v[0]), .Busy(busy_v[0]), .MulDone(done_v[0]));
  ex_mul_sequencer #(.BITS_PER_CYCLE(1)) u1 (.Clk(Clk), .Reset(Reset), .Flush(Flush), .Valid_ID_EX(Valid),
    .IsMul_ID_EX(IsMul), .RegWrite_ID_EX(RegWr), .Rd_ID_EX(Rd), .OpA(OpA), .OpB(OpB), .ALUresult(ALU),
    .Stall(stall_v[1]), .RegWrite_EX(rw_v[1]), .Result_EX(res_v[1]), .Rd_EX(rd_v[1]), .Busy(busy_v[1]), .MulDone(done_v[1]));
  ex_mul_sequencer #(.BITS_PER_CYCLE(8)) u2 (.Clk(Clk), .Reset(Reset), .Flush(Flush), .Valid_ID_EX(Valid),
    .IsMul_ID_EX(IsMul), .RegWrite_ID_EX(RegWr), .Rd_ID_EX(Rd), .OpA(OpA), .OpB(OpB), .ALUresult(ALU),
    .Stall(stall_v[2]), .RegWrite_EX(rw_v[2]), .Result_EX(res_v[2]), .Rd_EX(rd_v[2]), .Busy(busy_v[2]), .MulDone(done_v[2]));

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", n, a, e, $time);
    end
  endtask

  // model: rem = 0 idle, ITER..1 busy cycles left, -1 the result cycle
  always @(posedge Clk or negedge Reset)
    for (int i = 0; i < 3; i++)
      if (!Reset) rem[i] = 0;
      else if (Flush) rem[i] = 0;
      else if (rem[i] == 0) begin
        if (Valid && IsMul) begin
          prod[i] = OpA * OpB;
          mrd[i]  = Rd;
          mrw[i]  = RegWr;
          rem[i]  = IT[i];
        end
      end else if (rem[i] == -1) rem[i] = 0;
      else rem[i] = rem[i] == 1 ? -1 : rem[i] - 1;

  always @(negedge Clk)
    for (int i = 0; i < 3; i++) begin
      est  = Reset && !Flush && (rem[i] > 0 || (rem[i] == 0 && Valid && IsMul));
      ebz  = Reset && rem[i] > 0;
      edn  = Reset && !Flush && rem[i] == -1;
      eres = !Reset ? 32'd0 : rem[i] == -1 ? prod[i] : ALU;
      erd  = !Reset ? 5'd0 : rem[i] == -1 ? mrd[i] : Rd;
      erw  = Reset && !Flush && erd != 0 && (rem[i] == -1 ? mrw[i] : rem[i] == 0 && Valid && !IsMul && RegWr);
      chk($sformatf("u%0d stall", i), 32'(stall_v[i]), 32'(est));
      chk($sformatf("u%0d busy", i), 32'(busy_v[i]), 32'(ebz));
      chk($sformatf("u%0d muldone", i), 32'(done_v[i]), 32'(edn));
      chk($sformatf("u%0d result", i), res_v[i], eres);
      chk($sformatf("u%0d rd", i), 32'(rd_v[i]), 32'(erd));
      chk($sformatf("u%0d regwrite", i), 32'(rw_v[i]), 32'(erw));
    end

  task automatic present(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    Flush = 0; Valid = 1; IsMul = 1; OpA = a; OpB = b; Rd = rd; RegWr = 1;
  endtask

  // wait (bounded) for the first MulDone of u0, or of all instances
  task automatic run(input bit all);
    bit got [3] = '{0, 0, 0};
    for (int i = 0; i < 3; i++) begin
      sc_c[i] = 0; r_c[i] = 'x; rd_c[i] = 'x; rw_c[i] = 'x;
    end
    for (int c = 0; c < 45; c++) begin
      @(negedge Clk);
      for (int i = 0; i < 3; i++)
        if (!got[i]) begin
          if (stall_v[i]) sc_c[i]++;
          if (done_v[i]) begin
            got[i] = 1; r_c[i] = res_v[i]; rd_c[i] = rd_v[i]; rw_c[i] = rw_v[i];
          end
        end
      @(posedge Clk); #1;
      if (got[0] && (!all || (got[1] && got[2]))) break;
    end
  endtask

  task automatic drain();
    Valid = 0; IsMul = 0; Flush = 0;
    repeat (40) @(posedge Clk);
    #1;
  endtask

  initial begin
    Valid = 1; ALU = 32'hdead_beef; Rd = 5; RegWr = 1;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk("reset result", res_v[0], 32'd0);
    chk("reset rd", 32'(rd_v[0]), 32'd0);
    chk("reset regwrite", 32'(rw_v[0]), 32'd0);
    #2 Reset = 1;
    @(posedge Clk); #1;
    Valid = 1; IsMul = 0; ALU = 32'h0000_1234; Rd = 5; RegWr = 1;
    @(negedge Clk);
    chk("alu result", res_v[0], 32'h1234);
    chk("alu rd", 32'(rd_v[0]), 32'd5);
    chk("alu regwrite", 32'(rw_v[0]), 32'd1);
    chk("alu stall", 32'(stall_v[0]), 32'd0);
    @(posedge Clk); #1;
    present(7, 6, 3); run(1);
    chk("mul7x6 result", r_c[0], 32'd42);
    chk("mul7x6 rd", 32'(rd_c[0]), 32'd3);
    chk("mul7x6 regwrite", 32'(rw_c[0]), 32'd1);
    chk("mul7x6 stall cycles", sc_c[0], 17);
    chk("mul7x6 b1 result", r_c[1], 32'd42);
    chk("mul7x6 b8 result", r_c[2], 32'd42);
    drain();
    present(32'hffff_ffff, 32'hffff_ffff, 7); run(1);
    for (int i = 0; i < 3; i++) chk($sformatf("u%0d ones sq", i), r_c[i], 32'd1);
    chk("b2 stall cycles", sc_c[0], 17);
    chk("b1 stall cycles", sc_c[1], 33);
    chk("b8 stall cycles", sc_c[2], 5);
    drain();
    present(32'h0001_0000, 32'h0001_0000, 8); run(1);
    for (int i = 0; i < 3; i++) chk($sformatf("u%0d overflow", i), r_c[i], 32'd0);
    drain();
    present(9, 9, 4);
    repeat (5) @(posedge Clk);
    #1 Flush = 1;
    @(negedge Clk);
    chk("flush regwrite", 32'(rw_v[0]), 32'd0);
    chk("flush muldone", 32'(done_v[0]), 32'd0);
    chk("flush stall", 32'(stall_v[0]), 32'd0);
    @(posedge Clk); #1;
    Flush = 0; Valid = 1; IsMul = 0; ALU = 32'h0000_abcd; Rd = 6; RegWr = 1;
    @(negedge Clk);
    chk("post-flush busy", 32'(busy_v[0]), 32'd0);
    chk("post-flush result", res_v[0], 32'h0000_abcd);
    chk("post-flush regwrite", 32'(rw_v[0]), 32'd1);
    @(posedge Clk); #1;
    drain();
    present(11, 13, 9);
    repeat (4) @(posedge Clk);
    #1 Reset = 0; Valid = 0; IsMul = 0;
    #2;
    chk("mid-reset stall", 32'(stall_v[0]), 32'd0);
    chk("mid-reset busy", 32'(busy_v[0]), 32'd0);
    chk("mid-reset result", res_v[0], 32'd0);
    chk("mid-reset regwrite", 32'(rw_v[0]), 32'd0);
    #1 Reset = 1;
    @(posedge Clk); #1;
    present(3, 3, 10); run(1);
    for (int i = 0; i < 3; i++) chk($sformatf("u%0d 3x3", i), r_c[i], 32'd9);
    drain();
    present(2, 5, 1); run(0);
    chk("b2b first result", r_c[0], 32'd10);
    chk("b2b first rd", 32'(rd_c[0]), 32'd1);
    present(4, 4, 2); run(0);
    chk("b2b second result", r_c[0], 32'd16);
    chk("b2b second rd", 32'(rd_c[0]), 32'd2);
    chk("b2b second stall cycles", sc_c[0], 17);
    present(5, 5, 0); run(0);
    chk("rd0 result", r_c[0], 32'd25);
    chk("rd0 regwrite", 32'(rw_c[0]), 32'd0);
    drain();
    for (int c = 0; c < 3000; c++) begin
      Flush = $urandom % 20 == 0;
      Valid = $urandom % 4 != 0;
      IsMul = $urandom % 3 == 0;
      RegWr = 1'($urandom);
      Rd    = $urandom % 8 == 0 ? 5'd0 : 5'($urandom);
      OpA   = $urandom % 2 ? $urandom : $urandom % 256;
      OpB   = $urandom % 2 ? $urandom : $urandom % 256;
      ALU   = $urandom;
      @(posedge Clk); #1;
    end
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ex_mul_sequencer.md
Name: ex_mul_sequencer

Overview:
EX-stage controller that sequences a multi-cycle iterative multiplier alongside the single-cycle ALU. It sits between the ID_EX pipeline register and the EX_WB register. It stalls the upstream pipeline while a MUL runs and inserts bubbles into EX_WB. When the MUL completes, it steers either the ALU result or the product, together with RegWrite and Rd, into EX_WB.

Parameters:
BITS_PER_CYCLE, 2, multiplier bits retired per BUSY cycle. Legal values are 1, 2, 4, 8. ITER = 32/BITS_PER_CYCLE (default 16).

Ports:
Clk  input  1  pipeline clock, rising edge.
Reset  input  1  asynchronous, active-low reset.
Flush  input  1  synchronous abort of the EX stage (branch/exception).
Valid_ID_EX  input  1  ID_EX holds a real instruction.
IsMul_ID_EX  input  1  instruction is MUL (low 32 bits of A*B).
RegWrite_ID_EX  input  1  instruction writes the register file.
Rd_ID_EX  input  5  destination register.
OpA  input  32  EX operand A (post-forwarding).
OpB  input  32  EX operand B.
ALUresult  input  32  single-cycle ALU output.
Stall  output  1  hold PC, IF_ID and ID_EX this cycle.
RegWrite_EX  output  1  to EX_WB RegWrite input.
Result_EX  output  32  to EX_WB ALUresult input.
Rd_EX  output  5  to EX_WB Rd input.
Busy  output  1  state is BUSY.
MulDone  output  1  one-cycle pulse in the DONE state.

Behaviour:
- Reset low (async):
  - state is IDLE; internal acc, multiplicand, multiplier, count, Rd_q and RegWrite_q are cleared to 0.
  - Stall=0, Busy=0, MulDone=0, RegWrite_EX=0, Result_EX=0, Rd_EX=0, all forced while Reset is low.
- States: IDLE, BUSY, DONE. Outputs are combinational from state and inputs; all internal registers update on the Clk rising edge.
- IDLE, with Valid_ID_EX=1 and IsMul_ID_EX=0 (pass-through):
  - Result_EX=ALUresult, Rd_EX=Rd_ID_EX, RegWrite_EX=RegWrite_ID_EX.
  - Stall=0. Zero added latency.
- IDLE, with Valid_ID_EX=0: RegWrite_EX=0 (bubble). Result_EX and Rd_EX still pass through.
- IDLE, with Valid_ID_EX=1 and IsMul_ID_EX=1 (accept cycle):
  - Stall=1, RegWrite_EX=0.
  - At the edge: latch OpA into multiplicand, OpB into multiplier, Rd_ID_EX into Rd_q, RegWrite_ID_EX into RegWrite_q; clear acc; count=0; go to BUSY.
- BUSY, each cycle:
  - Stall=1, Busy=1, RegWrite_EX=0.
  - acc += multiplicand * multiplier[BITS_PER_CYCLE-1:0], truncated to 32 bits.
  - multiplicand <<= BITS_PER_CYCLE; multiplier >>= BITS_PER_CYCLE; count++.
  - After ITER cycles, go to DONE.
- DONE, exactly 1 cycle:
  - Stall=0, MulDone=1, Result_EX=acc, Rd_EX=Rd_q, RegWrite_EX=RegWrite_q.
  - ID_EX inputs are ignored; ID_EX still holds the MUL and advances at this edge.
  - Next state is IDLE.
- MUL timing: Stall is high for ITER+1 cycles. The product is captured into EX_WB at the end of the DONE cycle, ITER+2 cycles after the accept cycle begins.
- Width: the product is the low 32 bits only; overflow is discarded silently and no flag is raised.
- Rd=0: RegWrite_EX is forced to 0 whenever Rd_EX==0, in all states.
- Flush=1 (priority over all but reset):
  - That cycle: RegWrite_EX=0, Stall=0, MulDone=0.
  - At the edge: state goes to IDLE; count and acc are cleared.
  - A MUL presented in IDLE with Flush=1 is not accepted.
- Back-to-back MULs: the DONE→IDLE transition is mandatory. A second MUL in ID_EX is accepted in the following IDLE cycle, with no overlap.
- Reset asserted mid-BUSY: the operation is abandoned with no write. After release, the block restarts in IDLE.

Test Plan:
1. ALU pass-through: ALU op with ALUresult=0x0000_1234, Rd=5, RegWrite=1 → same cycle, Result_EX=0x1234, Rd_EX=5, RegWrite_EX=1, Stall=0.
2. MUL 7*6, Rd=3, default parameter → Stall high for 17 cycles; in DONE, Result_EX=42, Rd_EX=3, RegWrite_EX=1, MulDone=1; then IDLE.
3. Truncation: 0xFFFF_FFFF*0xFFFF_FFFF → 0x0000_0001. 0x0001_0000*0x0001_0000 → 0x0000_0000. Repeat with BITS_PER_CYCLE=1 and 8; Stall high for 33 and 5 cycles respectively.
4. Flush in the 5th BUSY cycle → RegWrite_EX=0 throughout; no MulDone; state is IDLE next cycle. A following ALU op passes through unchanged.
5. Reset pulsed low mid-BUSY → all outputs 0 immediately. After release, a MUL 3*3 completes with 9.
6. Back-to-back MUL 2*5 (Rd=1) then MUL 4*4 (Rd=2) → two DONE cycles delivering 10 and 16, separated by one IDLE accept cycle. MUL with Rd=0 → RegWrite_EX stays 0.
